// File: rtl/alpha_iter_sched_if.sv
// rtl/alpha_iter_sched_if.sv - stream and core-side signal bundle for alpha_iter_sched
interface alpha_iter_sched_if #(
  parameter int J      = 14,
  parameter int I      = 7,
  parameter int A      = 2,
  parameter int W      = 8,
  parameter int ITER_W = 4
);
  logic [ITER_W-1:0]      cfg_iter;
  logic [J-1:0]           H_row;
  logic                   H_row_tvalid;
  logic                   H_row_tready;
  logic [J*W-1:0]         alpha_u_col;
  logic                   alpha_u_col_tvalid;
  logic                   alpha_u_col_tlast;
  logic                   alpha_u_col_tready;
  logic [I*J-1:0]         core_H_rows;
  logic                   core_H_tvalid;
  logic                   core_clr;
  logic [I*J*W-1:0]       core_alpha;
  logic                   core_alpha_tvalid;
  logic                   core_alpha_tlast;
  logic                   core_alpha_tready;
  logic [A*W-1:0]         init_alpha_j;
  logic [I*A*W-1:0]       upd_alpha;
  logic                   upd_tvalid;
  logic [J*W-1:0]         res_tdata;
  logic [$clog2(I):0]     res_row;
  logic                   res_tvalid;
  logic                   res_tlast;
  logic                   res_tready;
  logic [ITER_W-1:0]      iter_cnt;
  logic                   done;
  logic                   err;

  modport master (
    output cfg_iter, H_row, H_row_tvalid, alpha_u_col, alpha_u_col_tvalid,
           alpha_u_col_tlast, core_alpha_tready, upd_alpha, upd_tvalid, res_tready,
    input  H_row_tready, alpha_u_col_tready, core_H_rows, core_H_tvalid, core_clr,
           core_alpha, core_alpha_tvalid, core_alpha_tlast, init_alpha_j, res_tdata,
           res_row, res_tvalid, res_tlast, iter_cnt, done, err
  );

  modport slave (
    input  cfg_iter, H_row, H_row_tvalid, alpha_u_col, alpha_u_col_tvalid,
           alpha_u_col_tlast, core_alpha_tready, upd_alpha, upd_tvalid, res_tready,
    output H_row_tready, alpha_u_col_tready, core_H_rows, core_H_tvalid, core_clr,
           core_alpha, core_alpha_tvalid, core_alpha_tlast, init_alpha_j, res_tdata,
           res_row, res_tvalid, res_tlast, iter_cnt, done, err
  );
endinterface

// File: rtl/alpha_iter_sched.sv
// rtl/alpha_iter_sched.sv - iteration scheduler and alpha buffer for the cal_core array
// ALPHA_ZERO_CLAMP_EN: store zero update elements as 1.
module alpha_iter_sched #(
  parameter int J      = 14,
  parameter int I      = 7,
  parameter int A      = 2,
  parameter int W      = 8,
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alpha_iter_sched_if.slave bus
);
  localparam int IW  = (I > 1) ? $clog2(I) : 1;
  localparam int HCW = $clog2(I + 1);
  localparam int AW  = (A > 1) ? $clog2(A) : 1;
  localparam int ACW = $clog2(A + 1);
  localparam int JW  = (J > 1) ? $clog2(J) : 1;
  localparam int RW  = $clog2(I) + 1;

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_REPLAY = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]        state;
  logic              live;
  logic [HCW-1:0]    h_cnt;
  logic [ACW-1:0]    a_cnt;
  logic [AW-1:0]     rep_a;
  logic [AW-1:0]     out_a;
  logic [IW-1:0]     out_r;
  logic [JW-1:0]     upd_cnt;
  logic [ITER_W-1:0] iter_lat;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_nx;
  logic              h_valid_q;
  logic              err_q;
  logic              out_last;

  logic [J-1:0] h_buf     [I];
  logic [W-1:0] init_buf  [A][J];
  logic [W-1:0] alpha_buf [I][J][A];

  function automatic logic [W-1:0] fix(input logic [W-1:0] v);
`ifdef ALPHA_ZERO_CLAMP_EN
    return (v == '0) ? W'(1) : v;
`else
    return v;
`endif
  endfunction

  assign iter_nx  = iter_q + 1'b1;
  assign out_last = (out_r == IW'(I - 1)) && (out_a == AW'(A - 1));

  // live holds the stream readies low while in reset so every output reads 0
  assign bus.H_row_tready       = live && (state == S_LOAD) && (h_cnt < HCW'(I));
  assign bus.alpha_u_col_tready = live && (state == S_LOAD) && (a_cnt < ACW'(A));
  assign bus.core_H_tvalid      = h_valid_q;
  assign bus.core_clr           = (state == S_CLEAR);
  assign bus.core_alpha_tvalid  = (state == S_REPLAY);
  assign bus.core_alpha_tlast   = (state == S_REPLAY) && (rep_a == AW'(A - 1));
  assign bus.res_tvalid         = (state == S_OUT);
  assign bus.res_tlast          = (state == S_OUT) && out_last;
  assign bus.res_row            = RW'(out_r);
  assign bus.done               = (state == S_OUT) && bus.res_tready && out_last;
  assign bus.iter_cnt           = iter_q;
  assign bus.err                = err_q;

  always_comb begin
    bus.core_H_rows  = '0;
    bus.core_alpha   = '0;
    bus.init_alpha_j = '0;
    bus.res_tdata    = '0;
    for (int r = 0; r < I; r++) begin
      bus.core_H_rows[r*J +: J] = h_buf[r];
      for (int j = 0; j < J; j++)
        bus.core_alpha[(r*J + j)*W +: W] = (iter_q == '0) ? init_buf[rep_a][j]
                                                           : alpha_buf[r][j][rep_a];
    end
    for (int a = 0; a < A; a++)
      bus.init_alpha_j[a*W +: W] = init_buf[a][upd_cnt];
    for (int j = 0; j < J; j++)
      bus.res_tdata[j*W +: W] = alpha_buf[out_r][j][out_a];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      live      <= 1'b0;
      h_cnt     <= '0;
      a_cnt     <= '0;
      rep_a     <= '0;
      out_a     <= '0;
      out_r     <= '0;
      upd_cnt   <= '0;
      iter_lat  <= '0;
      iter_q    <= '0;
      h_valid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int r = 0; r < I; r++) begin
        h_buf[r] <= '0;
        for (int j = 0; j < J; j++)
          for (int a = 0; a < A; a++)
            alpha_buf[r][j][a] <= '0;
      end
      for (int a = 0; a < A; a++)
        for (int j = 0; j < J; j++)
          init_buf[a][j] <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        S_LOAD: begin
          if ((h_cnt == HCW'(I)) && (a_cnt == ACW'(A))) begin
            iter_lat  <= (bus.cfg_iter == '0) ? ITER_W'(1) : bus.cfg_iter;
            h_valid_q <= 1'b1;
            iter_q    <= '0;
            rep_a     <= '0;
            state     <= S_REPLAY;
          end else begin
            if (bus.H_row_tvalid && bus.H_row_tready) begin
              h_buf[h_cnt[IW-1:0]] <= bus.H_row;
              h_cnt                <= h_cnt + 1'b1;
            end
            if (bus.alpha_u_col_tvalid && bus.alpha_u_col_tready) begin
              for (int j = 0; j < J; j++)
                init_buf[a_cnt[AW-1:0]][j] <= bus.alpha_u_col[j*W +: W];
              // early tlast: close the column stream and blank the columns never sent
              if (bus.alpha_u_col_tlast && (a_cnt != ACW'(A - 1))) begin
                err_q <= 1'b1;
                a_cnt <= ACW'(A);
                for (int k = 0; k < A; k++)
                  if (k > int'(a_cnt))
                    for (int j = 0; j < J; j++)
                      init_buf[k][j] <= '0;
              end else begin
                a_cnt <= a_cnt + 1'b1;
              end
            end
          end
        end
        S_REPLAY: begin
          if (bus.core_alpha_tready) begin
            if (rep_a == AW'(A - 1)) begin
              rep_a   <= '0;
              upd_cnt <= '0;
              state   <= S_WAIT;
            end else begin
              rep_a <= rep_a + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (bus.upd_tvalid) begin
            for (int r = 0; r < I; r++)
              for (int a = 0; a < A; a++)
                alpha_buf[r][upd_cnt][a] <= fix(bus.upd_alpha[(r*A + a)*W +: W]);
            if (upd_cnt == JW'(J - 1)) begin
              upd_cnt <= '0;
              iter_q  <= iter_nx;
              out_r   <= '0;
              out_a   <= '0;
              state   <= (iter_nx == iter_lat) ? S_OUT : S_CLEAR;
            end else begin
              upd_cnt <= upd_cnt + 1'b1;
            end
          end
        end
        S_CLEAR: state <= S_REPLAY;
        S_OUT: begin
          if (bus.res_tready) begin
            if (out_last) begin
              h_valid_q <= 1'b0;
              h_cnt     <= '0;
              a_cnt     <= '0;
              out_r     <= '0;
              out_a     <= '0;
              state     <= S_LOAD;
            end else if (out_a == AW'(A - 1)) begin
              out_a <= '0;
              out_r <= out_r + 1'b1;
            end else begin
              out_a <= out_a + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
      if (bus.upd_tvalid && (state != S_WAIT))
        err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alpha_iter_sched.sv
// tb/tb_alpha_iter_sched.sv - directed self-checking bench for alpha_iter_sched (I=2, J=3, A=2)
module tb_alpha_iter_sched;
  localparam int J = 3, I = 2, A = 2, W = 8, ITER_W = 4;
`ifdef ALPHA_ZERO_CLAMP_EN
  localparam logic [7:0] ZVAL = 8'd1;
`else
  localparam logic [7:0] ZVAL = 8'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alpha_iter_sched_if #(.J(J), .I(I), .A(A), .W(W), .ITER_W(ITER_W)) bus ();
  alpha_iter_sched #(.J(J), .I(I), .A(A), .W(W), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int pat_i = 0;
  int clr_n = 0;
  bit stall = 1'b0;
  bit zero_mode = 1'b0;
  logic [23:0] init_col [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic next_rdy(output logic r);
    r = stall ? ((pat_i % 4 == 0) || (pat_i % 4 == 3)) : 1'b1;
    pat_i++;
  endtask

  function automatic logic [7:0] upd_val(input int k, input int r, input int a, input int j);
    if (zero_mode && r == 1 && a == 1 && j == 2) return 8'd0;
    return 8'(10 * (r * A + a + 1) + j + 64 * k);
  endfunction

  function automatic logic [7:0] stored(input int k, input int r, input int a, input int j);
    logic [7:0] v;
    v = upd_val(k, r, a, j);
    return (v == 8'd0) ? ZVAL : v;
  endfunction

  function automatic logic [23:0] st_col(input int k, input int r, input int a);
    return {stored(k, r, a, 2), stored(k, r, a, 1), stored(k, r, a, 0)};
  endfunction

  function automatic logic [31:0] upd_beat(input int k, input int j);
    logic [31:0] b;
    for (int r = 0; r < I; r++)
      for (int a = 0; a < A; a++)
        b[(r*A + a)*8 +: 8] = upd_val(k, r, a, j);
    return b;
  endfunction

  task automatic reset_outputs(input string tag);
    check({tag, "_hrdy"}, bus.H_row_tready, 0);
    check({tag, "_ardy"}, bus.alpha_u_col_tready, 0);
    check({tag, "_hval"}, bus.core_H_tvalid, 0);
    check({tag, "_hrows"}, bus.core_H_rows, 0);
    check({tag, "_clr"}, bus.core_clr, 0);
    check({tag, "_calpha"}, bus.core_alpha, 0);
    check({tag, "_cval"}, {bus.core_alpha_tvalid, bus.core_alpha_tlast}, 0);
    check({tag, "_init"}, bus.init_alpha_j, 0);
    check({tag, "_res"}, {bus.res_tdata, bus.res_row, bus.res_tvalid, bus.res_tlast}, 0);
    check({tag, "_iter"}, bus.iter_cnt, 0);
    check({tag, "_done_err"}, {bus.done, bus.err}, 0);
  endtask

  task automatic load(input logic [2:0] r0, input logic [2:0] r1,
                      input logic [23:0] c0, input logic [23:0] c1, input bit early_last);
    int n = 0;
    while (!(bus.H_row_tready && bus.alpha_u_col_tready) && n < 20) begin step; n++; end
    check("load_rdy", {bus.H_row_tready, bus.alpha_u_col_tready}, 2'b11);
    bus.H_row = r0; bus.H_row_tvalid = 1'b1;
    bus.alpha_u_col = c0; bus.alpha_u_col_tvalid = 1'b1; bus.alpha_u_col_tlast = early_last;
    step;
    bus.H_row = r1;
    if (early_last) begin
      bus.alpha_u_col_tvalid = 1'b0;
      check("tlast_err", bus.err, 1);
      check("a_rdy_closed", bus.alpha_u_col_tready, 0);
    end else begin
      bus.alpha_u_col = c1; bus.alpha_u_col_tlast = 1'b1;
    end
    step;
    bus.H_row_tvalid = 1'b0; bus.alpha_u_col_tvalid = 1'b0; bus.alpha_u_col_tlast = 1'b0;
    step;
    check("core_H_tvalid", bus.core_H_tvalid, 1);
    check("core_H_rows", bus.core_H_rows, {r1, r0});
  endtask

  task automatic replay(input logic [47:0] e0, input logic [47:0] e1, input bit inject);
    int n = 0;
    logic r;
    bus.core_alpha_tready = 1'b0;
    while (!bus.core_alpha_tvalid && n < 20) begin step; n++; end
    check("rep_valid", bus.core_alpha_tvalid, 1);
    if (inject) begin
      bus.upd_alpha = 32'hDEADBEEF; bus.upd_tvalid = 1'b1;
      step;
      bus.upd_tvalid = 1'b0;
      check("stray_err", bus.err, 1);
    end
    for (int b = 0; b < 2; b++) begin
      n = 0;
      do begin
        next_rdy(r);
        bus.core_alpha_tready = r;
        check("rep_data", bus.core_alpha, (b == 0) ? e0 : e1);
        check("rep_last", bus.core_alpha_tlast, b == 1);
        step; n++;
      end while (!r && n < 10);
    end
    bus.core_alpha_tready = 1'b0;
    check("rep_end", bus.core_alpha_tvalid, 0);
  endtask

  task automatic updates(input int k, input bit chk_init);
    for (int j = 0; j < J; j++) begin
      bus.upd_alpha = upd_beat(k, j); bus.upd_tvalid = 1'b1;
      if (chk_init)
        check("init_alpha_j", bus.init_alpha_j, {init_col[1][j*8 +: 8], init_col[0][j*8 +: 8]});
      step;
    end
    bus.upd_tvalid = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    logic r;
    bit last;
    for (int ri = 0; ri < I; ri++)
      for (int a = 0; a < A; a++) begin
        last = (ri == I - 1) && (a == A - 1);
        n = 0;
        do begin
          next_rdy(r);
          bus.res_tready = r;
          check("res_valid", bus.res_tvalid, 1);
          check("res_data", bus.res_tdata, st_col(k, ri, a));
          check("res_row", bus.res_row, ri);
          check("res_last", bus.res_tlast, last);
          check("done", bus.done, r && last);
          step; n++;
        end while (!r && n < 10);
      end
    bus.res_tready = 1'b0;
    check("done_after", bus.done, 0);
    check("H_tvalid_clr", bus.core_H_tvalid, 0);
  endtask

  task automatic job(input int iters, input bit inject_k1);
    for (int k = 0; k < iters; k++) begin
      if (k == 0)
        replay({init_col[0], init_col[0]}, {init_col[1], init_col[1]}, 1'b0);
      else
        replay({st_col(k-1, 1, 0), st_col(k-1, 0, 0)}, {st_col(k-1, 1, 1), st_col(k-1, 0, 1)},
               inject_k1 && k == 1);
      updates(k, k == 0);
      if (k < iters - 1) begin
        check("clr_pulse", bus.core_clr, 1);
        check("clr_no_valid", bus.core_alpha_tvalid, 0);
        clr_n++;
        step;
        check("clr_once", bus.core_clr, 0);
      end
    end
    check("iter_cnt", bus.iter_cnt, iters);
    drain(iters - 1);
    check("iter_hold", bus.iter_cnt, iters);
  endtask

  initial begin
    bus.cfg_iter = '0; bus.H_row = '0; bus.H_row_tvalid = 1'b0;
    bus.alpha_u_col = '0; bus.alpha_u_col_tvalid = 1'b0; bus.alpha_u_col_tlast = 1'b0;
    bus.core_alpha_tready = 1'b0; bus.upd_alpha = '0; bus.upd_tvalid = 1'b0; bus.res_tready = 1'b0;
    step; step;
    reset_outputs("rst");
    rst_n = 1'b1;

    init_col[0] = {8'd3, 8'd2, 8'd1};
    init_col[1] = {8'd6, 8'd5, 8'd4};
    bus.cfg_iter = 4'd1;
    load(3'b101, 3'b011, init_col[0], init_col[1], 1'b0);
    job(1, 1'b0);
    check("err_clean1", bus.err, 0);

    stall = 1'b1; zero_mode = 1'b1; clr_n = 0;
    bus.cfg_iter = 4'd3;
    load(3'b110, 3'b001, init_col[0], init_col[1], 1'b0);
    job(3, 1'b0);
    check("clr_count", clr_n, 2);
    check("err_clean2", bus.err, 0);

    stall = 1'b0; zero_mode = 1'b0;
    init_col[0] = {8'd9, 8'd8, 8'd7};
    init_col[1] = 24'd0;
    bus.cfg_iter = 4'd1;
    load(3'b111, 3'b010, init_col[0], {8'd6, 8'd5, 8'd4}, 1'b1);
    replay({init_col[0], init_col[0]}, 48'd0, 1'b0);
    bus.upd_alpha = upd_beat(0, 0); bus.upd_tvalid = 1'b1;
    step;
    bus.upd_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_outputs("midrst");
    step;
    rst_n = 1'b1;

    init_col[0] = {8'd3, 8'd2, 8'd1};
    init_col[1] = {8'd6, 8'd5, 8'd4};
    bus.cfg_iter = 4'd2;
    load(3'b101, 3'b011, init_col[0], init_col[1], 1'b0);
    job(2, 1'b1);

    bus.cfg_iter = 4'd0;
    load(3'b011, 3'b100, init_col[0], init_col[1], 1'b0);
    job(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
